// File: rtl/smc_go_sequencer.sv
// Pushbutton conditioning and run/stop/single-step pacing for the simple memory controller.
// Optional build macro SMC_AUTOSTOP_EN: RUN stops by itself after 16 newgo strobes (one memory pass).
module smc_go_sequencer #(
  parameter int CW        = 26,
  parameter int DIV_MAX   = 49_999_999,
  parameter int DB_CYCLES = 500_000
) (
  input  logic          MAX10_CLK1_50,
  input  logic          reset,
  input  logic [1:0]    KEY,
  input  logic [1:0]    SPD,
  output logic          newgo,
  output logic [CW-1:0] divby,
  output logic [CW-1:0] divby_c,
  output logic          run,
  output logic [1:0]    key_pulse
);

  localparam int            DBW        = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  DIV_MAX_W = CW'(DIV_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     db_q, db_dly_q;
  logic [DBW-1:0] cnt_q [2];
  logic [1:0]     key_pulse_q;
  logic [1:0]     key_pulse_d;

  state_t         state_q;
  logic           newgo_q;
  logic           run_q;
  logic [CW-1:0]  divby_q, divby_d;
  logic [CW-1:0]  divby_c_q;
`ifdef SMC_AUTOSTOP_EN
  logic [3:0]     gocnt_q;
`endif

  assign key_pulse_d = db_dly_q & ~db_q;
  assign divby_d     = DIV_MAX_W >> {SPD, 1'b0};

  // Key path: 2-FF synchronizer, stability counter, delayed falling-edge strobe.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      db_q        <= 2'b11;
      db_dly_q    <= 2'b11;
      key_pulse_q <= 2'b00;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= KEY;
      sync2_q     <= sync1_q;
      db_dly_q    <= db_q;
      key_pulse_q <= key_pulse_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (cnt_q[i] == DB_LAST) begin
            db_q[i]  <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + DBW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Pacing FSM; every output is registered from the chosen next state.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      newgo_q   <= 1'b0;
      run_q     <= 1'b0;
      divby_q   <= DIV_MAX_W;
      divby_c_q <= '0;
`ifdef SMC_AUTOSTOP_EN
      gocnt_q   <= 4'd0;
`endif
    end else begin
      divby_q <= divby_d;
      case (state_q)
        S_IDLE: begin
          newgo_q   <= 1'b0;
          divby_c_q <= '0;
          if (key_pulse_q[0]) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
`ifdef SMC_AUTOSTOP_EN
            gocnt_q <= 4'd0;
`endif
          end else if (key_pulse_q[1]) begin
            state_q <= S_STEP;
            newgo_q <= 1'b1;
          end
        end
        S_STEP: begin
          newgo_q <= 1'b0;
          state_q <= S_IDLE;
        end
        S_RUN: begin
          // Stop outranks a terminal count landing on the same edge.
          if (key_pulse_q[0]) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            newgo_q   <= 1'b0;
            divby_c_q <= '0;
          end else if (divby_c_q >= divby_q) begin
            divby_c_q <= '0;
            newgo_q   <= 1'b1;
`ifdef SMC_AUTOSTOP_EN
            gocnt_q   <= gocnt_q + 4'd1;
            if (gocnt_q == 4'd15) begin
              state_q <= S_IDLE;
              run_q   <= 1'b0;
            end
`endif
          end else begin
            divby_c_q <= divby_c_q + CW'(1);
            newgo_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          run_q     <= 1'b0;
          newgo_q   <= 1'b0;
          divby_c_q <= '0;
        end
      endcase
    end
  end

  assign newgo     = newgo_q;
  assign divby     = divby_q;
  assign divby_c   = divby_c_q;
  assign run       = run_q;
  assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_smc_go_sequencer.sv
// Scoreboard bench for smc_go_sequencer with DIV_MAX=7, DB_CYCLES=4, CW=26.
module tb_smc_go_sequencer;
  localparam int CW = 26;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    KEY = 2'b11;
  logic [1:0]    SPD = 2'b00;
  logic          newgo;
  logic [CW-1:0] divby, divby_c;
  logic          run;
  logic [1:0]    key_pulse;

  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  int            go_q[$];
  int            kp_t[$];
  logic [1:0]    kp_v[$];

  smc_go_sequencer #(.CW(CW), .DIV_MAX(7), .DB_CYCLES(4)) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (rst),
    .KEY           (KEY),
    .SPD           (SPD),
    .newgo         (newgo),
    .divby         (divby),
    .divby_c       (divby_c),
    .run           (run),
    .key_pulse     (key_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_go(input int t0, input int step, input int n);
    for (int k = 0; k < n; k++) go_q.push_back(t0 + k * step);
  endtask

  task automatic push_kp(input int t, input logic [1:0] v);
    kp_t.push_back(t);
    kp_v.push_back(v);
  endtask

  // Monitor: pops expected strobe times whenever the DUT presents a strobe.
  initial begin
    int t;
    logic [1:0] v;
    forever begin
      @(negedge clk);
      while (go_q.size() > 0 && go_q[0] < cyc) begin
        tests++; fails++;
        $display("FAIL newgo_missed: no pulse seen, expected one at cycle %0d", go_q.pop_front());
      end
      while (kp_t.size() > 0 && kp_t[0] < cyc) begin
        tests++; fails++;
        $display("FAIL key_pulse_missed: no pulse seen, expected one at cycle %0d", kp_t.pop_front());
        void'(kp_v.pop_front());
      end
      if (newgo) begin
        if (go_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL newgo_unexpected: pulse at cycle %0d, expected none", cyc);
        end else begin
          check("newgo_cycle", cyc, go_q.pop_front());
        end
      end
      if (key_pulse != 2'b00) begin
        if (kp_t.size() == 0) begin
          tests++; fails++;
          $display("FAIL key_pulse_unexpected: value %0d at cycle %0d, expected none", key_pulse, cyc);
        end else begin
          t = kp_t.pop_front();
          v = kp_v.pop_front();
          check("key_pulse_cycle", cyc, t);
          check("key_pulse_bits", key_pulse, v);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_newgo", newgo, 0);
    check("rst_divby", divby, 7);
    check("rst_divby_c", divby_c, 0);
    check("rst_run", run, 0);
    check("rst_key_pulse", key_pulse, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Start RUN at SPD=0, then stop it; then a short glitch.
    c = cyc; KEY = 2'b10; push_kp(c + 7, 2'b01); push_go(c + 16, 8, 2);
    wait_until(c + 7);  check("a_run_before", run, 0);
    wait_until(c + 8);  check("a_run_on", run, 1); check("a_divby", divby, 7);
    wait_until(c + 10); KEY = 2'b11;
    wait_until(c + 13); check("a_divby_c5", divby_c, 5);
    wait_until(c + 15); check("a_divby_c7", divby_c, 7);
    wait_until(c + 20); KEY = 2'b10; push_kp(c + 27, 2'b01);
    wait_until(c + 27); check("a_divby_c3", divby_c, 3); check("a_run_still", run, 1);
    wait_until(c + 28); check("a_run_off", run, 0); check("a_divby_c_clr", divby_c, 0);
    wait_until(c + 30); KEY = 2'b11;
    wait_until(c + 45); KEY = 2'b10;
    wait_until(c + 47); KEY = 2'b11;
    wait_until(c + 60); check("glitch_run", run, 0);

    // SPD=1: newgo every 2 cycles.
    c = cyc; SPD = 2'd1;
    wait_until(c + 1); check("b_divby", divby, 1);
    wait_until(c + 2);
    c = cyc; KEY = 2'b10; push_kp(c + 7, 2'b01); push_go(c + 10, 2, 9);
    wait_until(c + 10); KEY = 2'b11;
    wait_until(c + 20); KEY = 2'b10; push_kp(c + 27, 2'b01);
    wait_until(c + 28); check("b_run_off", run, 0);
    wait_until(c + 30); KEY = 2'b11;
    wait_until(c + 45);

    // SPD drop mid-count wraps at once.
    SPD = 2'd0;
    c = cyc; KEY = 2'b10; push_kp(c + 7, 2'b01); push_go(c + 15, 2, 7);
    wait_until(c + 10); KEY = 2'b11;
    wait_until(c + 13); check("c_divby_c5", divby_c, 5); SPD = 2'd1;
    wait_until(c + 14); check("c_divby", divby, 1); check("c_divby_c6", divby_c, 6);
    wait_until(c + 15); check("c_wrap", divby_c, 0);
    wait_until(c + 20); KEY = 2'b10; push_kp(c + 27, 2'b01);
    wait_until(c + 28); check("c_run_off", run, 0);
    wait_until(c + 30); KEY = 2'b11;
    wait_until(c + 45);

    // Single step from IDLE.
    SPD = 2'd0;
    c = cyc; KEY = 2'b01; push_kp(c + 7, 2'b10); push_go(c + 8, 1, 1);
    wait_until(c + 8);  check("d_step_run", run, 0);
    wait_until(c + 9);  check("d_step_divby_c", divby_c, 0); check("d_step_run2", run, 0);
    wait_until(c + 10); KEY = 2'b11;
    wait_until(c + 25);

    // Step ignored in RUN; stop on the terminal-count edge suppresses newgo.
    c = cyc; KEY = 2'b10; push_kp(c + 7, 2'b01); push_go(c + 16, 8, 4);
    wait_until(c + 10); KEY = 2'b11;
    wait_until(c + 20); KEY = 2'b01; push_kp(c + 27, 2'b10);
    wait_until(c + 29); check("e_run_after_step", run, 1);
    wait_until(c + 30); KEY = 2'b11;
    wait_until(c + 40); KEY = 2'b10; push_kp(c + 47, 2'b01);
    wait_until(c + 47); check("e_divby_c7", divby_c, 7);
    wait_until(c + 48); check("e_run_off", run, 0); check("e_divby_c0", divby_c, 0);
    wait_until(c + 50); KEY = 2'b11;
    wait_until(c + 65);

    // Asynchronous reset in the middle of RUN.
    c = cyc; KEY = 2'b10; push_kp(c + 7, 2'b01);
    wait_until(c + 10); KEY = 2'b11;
    wait_until(c + 13); check("f_divby_c5", divby_c, 5);
    #2 rst = 1'b1;
    #1;
    check("f_rst_newgo", newgo, 0);
    check("f_rst_divby_c", divby_c, 0);
    check("f_rst_divby", divby, 7);
    check("f_rst_run", run, 0);
    check("f_rst_key_pulse", key_pulse, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Long RUN at SPD=1: autostop after 16 strobes, or keep going without it.
    SPD = 2'd1;
    @(negedge clk); @(negedge clk);
    c = cyc; KEY = 2'b10; push_kp(c + 7, 2'b01);
`ifdef SMC_AUTOSTOP_EN
    push_go(c + 10, 2, 16);
    wait_until(c + 10); KEY = 2'b11;
    wait_until(c + 39); check("g_run_before_16", run, 1);
    wait_until(c + 40); check("g_autostop_run", run, 0);
    wait_until(c + 60);
`else
    push_go(c + 10, 2, 24);
    wait_until(c + 10); KEY = 2'b11;
    wait_until(c + 41); check("g_run_past_16", run, 1);
    wait_until(c + 50); KEY = 2'b10; push_kp(c + 57, 2'b01);
    wait_until(c + 58); check("g_run_off", run, 0);
    wait_until(c + 60); KEY = 2'b11;
    wait_until(c + 75);
`endif

    repeat (3) @(negedge clk);
    check("leftover_newgo", go_q.size(), 0);
    check("leftover_key_pulse", kp_t.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
